// File: rtl/lcd_pkg.sv
// Shared types for the LCD pixel output stage.
// Stream states and the default RGB888 FIFO entry layout.
package lcd_pkg;

  typedef enum logic {
    WAIT_SOF,
    RUN
  } stream_state_t;

  localparam int RGB888_W = 24;

  typedef struct packed {
    logic                sof;
    logic [RGB888_W-1:0] data;
  } pix_entry_t;

endpackage

// File: rtl/lcd_pixel_fifo.sv
// Single-clock FIFO with occupancy count.
// Head entry is visible on rdata whenever the FIFO is non-empty.
module lcd_pixel_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap on overflow.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/lcd_pixel_stream.sv
// LCD pixel output stage: FIFO-buffered pixels popped on data_en,
// with registered syncs and SOF-based frame resynchronisation.
module lcd_pixel_stream
  import lcd_pkg::*;
#(
  parameter int PIX_W = 24,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset_L,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PIX_W-1:0]           in_data,
  input  logic                       in_sof,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       de_in,
  output logic                       hsync,
  output logic                       vsync,
  output logic                       data_en,
  output logic [PIX_W-1:0]           pixel,
  output logic                       underflow,
  output logic                       frame_err,
  input  logic                       clear_err,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int EW = PIX_W + 1;

  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [EW-1:0]    head;
  logic             head_sof;
  logic [PIX_W-1:0] head_data;

  stream_state_t    state;
  stream_state_t    state_nx;
  logic             vs_rise;
  logic             first_pop;
  logic             first_nx;
  logic [PIX_W-1:0] pixel_nx;
  logic             uf_set;
  logic             fe_set;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;
  assign head_sof = head[EW-1];
  assign head_data = head[PIX_W-1:0];
  // The registered vsync output doubles as the edge-detect delay.
  assign vs_rise  = vsync_in && !vsync;

  lcd_pixel_fifo #(
    .WIDTH(EW),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clock  (clock),
    .reset_L(reset_L),
    .push   (push),
    .wdata  ({in_sof, in_data}),
    .pop    (pop),
    .rdata  (head),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  always_comb begin
    state_nx = state;
    first_nx = first_pop;
    pop      = 1'b0;
    pixel_nx = '0;
    uf_set   = 1'b0;
    fe_set   = 1'b0;
    unique case (state)
      WAIT_SOF: begin
        if (!empty && !head_sof) begin
          pop = 1'b1;
        end else if (!empty && vs_rise) begin
          state_nx = RUN;
          first_nx = 1'b1;
        end
      end
      RUN: begin
        if (vs_rise && !empty && !head_sof) begin
          fe_set   = 1'b1;
          state_nx = WAIT_SOF;
        end else begin
          if (vs_rise) begin
            first_nx = 1'b1;
          end
          if (de_in && empty) begin
            uf_set = 1'b1;
          end else if (de_in) begin
            pop      = 1'b1;
            pixel_nx = head_data;
            first_nx = 1'b0;
            // A SOF pixel mid-frame is still shown but flagged.
            if (head_sof && !(vs_rise || first_pop)) begin
              fe_set = 1'b1;
            end
          end
        end
      end
      default: state_nx = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state     <= WAIT_SOF;
      first_pop <= 1'b0;
      hsync     <= 1'b0;
      vsync     <= 1'b0;
      data_en   <= 1'b0;
      pixel     <= '0;
      underflow <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      first_pop <= first_nx;
      hsync     <= hsync_in;
      vsync     <= vsync_in;
      data_en   <= de_in;
      pixel     <= pixel_nx;
      underflow <= uf_set || (underflow && !clear_err);
      frame_err <= fe_set || (frame_err && !clear_err);
    end
  end

endmodule

// File: tb/tb_lcd_pixel_stream.sv
// Self-checking bench for lcd_pixel_stream.
// Queue-based reference model advanced once per clock.
module tb_lcd_pixel_stream;
  import lcd_pkg::*;

  localparam int PIX_W = 24;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clock     = 1'b0;
  logic             reset_L   = 1'b1;
  logic             in_valid  = 1'b0;
  logic             in_sof    = 1'b0;
  logic [PIX_W-1:0] in_data   = '0;
  logic             hsync_in  = 1'b0;
  logic             vsync_in  = 1'b0;
  logic             de_in     = 1'b0;
  logic             clear_err = 1'b0;
  logic             in_ready;
  logic             hsync;
  logic             vsync;
  logic             data_en;
  logic [PIX_W-1:0] pixel;
  logic             underflow;
  logic             frame_err;
  logic [LW-1:0]    level;

  int checks   = 0;
  int failures = 0;

  pix_entry_t  q[$];
  logic        m_run, m_hs, m_vs, m_de, m_uf, m_fe;
  int          m_pops;
  logic [23:0] m_pix;
  logic [34:0] obs;

  lcd_pixel_stream #(
    .PIX_W(PIX_W),
    .DEPTH(DEPTH)
  ) dut (
    .clock    (clock),
    .reset_L  (reset_L),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sof   (in_sof),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .de_in    (de_in),
    .hsync    (hsync),
    .vsync    (vsync),
    .data_en  (data_en),
    .pixel    (pixel),
    .underflow(underflow),
    .frame_err(frame_err),
    .clear_err(clear_err),
    .level    (level)
  );

  always #5 clock = ~clock;

  assign obs = {in_ready, hsync, vsync, data_en,
                underflow, frame_err, level, pixel};

  function automatic logic [34:0] expv();
    logic          rdy;
    logic [LW-1:0] lv;
    rdy = (q.size() != DEPTH);
    lv  = LW'(q.size());
    return {rdy, m_hs, m_vs, m_de, m_uf, m_fe, lv, m_pix};
  endfunction

  task automatic model_reset();
    q.delete();
    m_run = 0; m_hs = 0; m_vs = 0; m_de = 0;
    m_uf = 0; m_fe = 0; m_pops = 0; m_pix = '0;
  endtask

  // Frame rules: m_pops counts display pops since the last vsync rise.
  task automatic model_tick();
    logic       vr, emp, dopop, uf, fe, acc;
    pix_entry_t h, e;
    logic [23:0] np;
    vr  = vsync_in && !m_vs;
    emp = (q.size() == 0);
    h   = emp ? '0 : q[0];
    acc = in_valid && (q.size() < DEPTH);
    dopop = 0; uf = 0; fe = 0; np = '0;
    if (vr) m_pops = 0;
    if (!m_run) begin
      if (!emp && !h.sof) dopop = 1;
      else if (!emp && vr) m_run = 1;
    end else if (vr && !emp && !h.sof) begin
      fe = 1;
      m_run = 0;
    end else if (de_in) begin
      if (emp) uf = 1;
      else begin
        dopop = 1;
        np = h.data;
        if (h.sof && m_pops > 0) fe = 1;
        m_pops++;
      end
    end
    if (dopop) void'(q.pop_front());
    if (acc) begin
      e.sof = in_sof;
      e.data = in_data;
      q.push_back(e);
    end
    m_uf  = uf || (m_uf && !clear_err);
    m_fe  = fe || (m_fe && !clear_err);
    m_pix = np;
    m_hs  = hsync_in;
    m_vs  = vsync_in;
    m_de  = de_in;
  endtask

  task automatic tick();
    model_tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2 reset_L = 1'b0;
    #2;
    checks++;
    if (obs !== expv() || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", obs, expv());
    end
    #8 reset_L = 1'b1;
    tick();
    checks++;
    if (obs !== expv()) begin
      failures++;
      $display("FAIL reset_idle got=%h exp=%h", obs, expv());
    end
  endtask

  task automatic test_basic_frame();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_sof = (i == 0); in_data = 24'(i + 1);
      tick();
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL basic_fill i=%0d got=%h exp=%h", i, obs, expv());
      end
    end
    in_valid = 0; in_sof = 0;
    vsync_in = 1;
    tick();
    vsync_in = 0;
    for (int i = 0; i < 8; i++) begin
      de_in = 1; hsync_in = 1;
      tick();
      checks++;
      if (obs !== expv() || pixel !== 24'(i + 1) || data_en !== 1'b1) begin
        failures++;
        $display("FAIL basic_pix i=%0d got=%h exp=%h", i, obs, expv());
      end
    end
    de_in = 0; hsync_in = 0;
    tick();
    checks++;
    if (level !== '0 || underflow !== 1'b0 || frame_err !== 1'b0 ||
        obs !== expv()) begin
      failures++;
      $display("FAIL basic_end got=%h exp=%h", obs, expv());
    end
  endtask

  task automatic test_full();
    logic [23:0] first;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1; in_sof = 0; in_data = 24'($urandom);
      if (i == 0) first = in_data;
      tick();
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL full_fill i=%0d got=%h exp=%h", i, obs, expv());
      end
    end
    checks++;
    if (level !== LW'(16) || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL full_level got=%0d ready=%b exp=16 ready=0",
               level, in_ready);
    end
    de_in = 1; in_data = 24'($urandom);
    tick();
    checks++;
    if (level !== LW'(15) || pixel !== first || obs !== expv()) begin
      failures++;
      $display("FAIL full_pop got=%h exp=%h", obs, expv());
    end
    in_data = 24'($urandom);
    tick();
    checks++;
    if (level !== LW'(15) || obs !== expv()) begin
      failures++;
      $display("FAIL full_pushpop got=%h exp=%h", obs, expv());
    end
    in_valid = 0;
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      tick();
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL full_drain i=%0d got=%h exp=%h", i, obs, expv());
      end
    end
    de_in = 0;
    tick();
    checks++;
    if (level !== '0 || underflow !== 1'b0 || obs !== expv()) begin
      failures++;
      $display("FAIL full_end got=%h exp=%h", obs, expv());
    end
  endtask

  task automatic test_underflow();
    logic [23:0] d [2];
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_sof = 0; in_data = 24'($urandom);
      d[i] = in_data;
      tick();
    end
    in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      de_in = 1;
      tick();
      checks++;
      if (pixel !== (i < 2 ? d[i] : 24'h0) ||
          underflow !== (i >= 2) || obs !== expv()) begin
        failures++;
        $display("FAIL underflow i=%0d got=%h exp=%h", i, obs, expv());
      end
    end
    de_in = 0; clear_err = 1;
    tick();
    clear_err = 0;
    checks++;
    if (underflow !== 1'b0 || obs !== expv()) begin
      failures++;
      $display("FAIL uf_clear got=%h exp=%h", obs, expv());
    end
  endtask

  task automatic test_misalign();
    in_valid = 1; in_sof = 0; in_data = 24'h123456;
    tick();
    in_valid = 0;
    vsync_in = 1;
    tick();
    vsync_in = 0;
    checks++;
    if (frame_err !== 1'b1 || obs !== expv()) begin
      failures++;
      $display("FAIL misalign_fe got=%h exp=%h", obs, expv());
    end
    for (int i = 0; i < 3; i++) begin
      de_in = 1;
      tick();
      checks++;
      if (pixel !== '0 || underflow !== 1'b0 || data_en !== 1'b1 ||
          obs !== expv()) begin
        failures++;
        $display("FAIL misalign_de i=%0d got=%h exp=%h", i, obs, expv());
      end
    end
    de_in = 0; clear_err = 1;
    tick();
    clear_err = 0;
    checks++;
    if (frame_err !== 1'b0 || obs !== expv()) begin
      failures++;
      $display("FAIL fe_clear got=%h exp=%h", obs, expv());
    end
  endtask

  task automatic test_resync();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_sof = (i == 3);
      in_data = (i == 3) ? 24'hABCDEF : 24'($urandom);
      tick();
    end
    in_valid = 0; in_sof = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL resync_idle i=%0d got=%h exp=%h", i, obs, expv());
      end
    end
    checks++;
    if (level !== LW'(1)) begin
      failures++;
      $display("FAIL resync_level got=%0d exp=1", level);
    end
    vsync_in = 1;
    tick();
    vsync_in = 0;
    de_in = 1;
    tick();
    de_in = 0;
    checks++;
    if (pixel !== 24'hABCDEF || frame_err !== 1'b0 || level !== '0 ||
        obs !== expv()) begin
      failures++;
      $display("FAIL resync_pix got=%h exp=%h", obs, expv());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sof    = ($urandom_range(0, 7) == 0);
      in_data   = 24'($urandom);
      de_in     = ($urandom_range(0, 4) < 3);
      hsync_in  = 1'($urandom_range(0, 1));
      clear_err = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 19) == 0) vsync_in = ~vsync_in;
      tick();
      checks++;
      if (obs !== expv()) begin
        failures++;
        $display("FAIL random i=%0d got=%h exp=%h", i, obs, expv());
      end
    end
    in_valid = 0; in_sof = 0; de_in = 0;
    hsync_in = 0; vsync_in = 0; clear_err = 0;
    tick();
  endtask

  task automatic test_async_reset();
    #2 reset_L = 1'b0;
    model_reset();
    #2 reset_L = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; in_sof = 1; in_data = 24'($urandom);
      tick();
    end
    in_valid = 0; in_sof = 0;
    de_in = 1; hsync_in = 1;
    tick();
    checks++;
    if (level !== LW'(5) || obs !== expv()) begin
      failures++;
      $display("FAIL async_pre got=%h exp=%h", obs, expv());
    end
    #2 reset_L = 1'b0;
    model_reset();
    #1;
    checks++;
    if (level !== '0 || in_ready !== 1'b1 || pixel !== '0 ||
        data_en !== 1'b0 || hsync !== 1'b0 || obs !== expv()) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", obs, expv());
    end
    #3 reset_L = 1'b1;
    de_in = 0; hsync_in = 0;
    tick();
    checks++;
    if (obs !== expv()) begin
      failures++;
      $display("FAIL async_post got=%h exp=%h", obs, expv());
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_full();
    test_underflow();
    test_misalign();
    test_resync();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
